// File: rtl/adder_operand_sequencer.sv
// Avalon-MM slave that waits for two raw operand ports to settle, performs
// one unsigned addition, latches operands and sum, and flags completion.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a software start or an auto-mode input change
// S_SETTLE | counting consecutive unchanged cycles of the raw inputs
// S_ADD    | latching snapshot operands and their sum
// S_DONE   | raising the done flag, then returning to idle
module adder_operand_sequencer #(
    parameter int DATA_W        = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port_a,
    input  logic [DATA_W-1:0] in_port_b,
    output logic [DATA_W:0]   sum_out,
    output logic              irq
);

    // Counter must hold STABLE_CYCLES-1; keep at least one bit when that is 0.
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA_A  = 3'd0;
    localparam logic [2:0] ADDR_DATA_B  = 3'd1;
    localparam logic [2:0] ADDR_RESULT  = 3'd2;
    localparam logic [2:0] ADDR_STATUS  = 3'd3;
    localparam logic [2:0] ADDR_CONTROL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] snap_a_q, snap_a_d;
    logic [DATA_W-1:0] snap_b_q, snap_b_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic [DATA_W:0]   result_q, result_d;
    logic              done_q, done_d;
    logic              missed_q, missed_d;
    logic              auto_q, auto_d;
    logic              irq_en_q, irq_en_d;
    logic [31:0]       readdata_q, readdata_d;

    logic wr_en;
    logic ctrl_wr;
    logic stat_wr;
    logic start_req;
    logic busy;
    logic raw_changed;
    logic auto_trig;

    assign wr_en       = chipselect & write;
    assign ctrl_wr     = wr_en && (address == ADDR_CONTROL);
    assign stat_wr     = wr_en && (address == ADDR_STATUS);
    assign start_req   = ctrl_wr & writedata[0];
    assign busy        = (state_q != S_IDLE);
    assign raw_changed = ({in_port_a, in_port_b} != {snap_a_q, snap_b_q});
    // Auto mode compares against the last latched operands, so an unchanged
    // input set never re-triggers after a completed sequence.
    assign auto_trig   = auto_q && ({in_port_a, in_port_b} != {data_a_q, data_b_q});

    // Sequencing FSM: settle counting, operand snapshot and the addition.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        snap_a_d = snap_a_q;
        snap_b_d = snap_b_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_req || auto_trig) begin
                    state_d  = S_SETTLE;
                    snap_a_d = in_port_a;
                    snap_b_d = in_port_b;
                    count_d  = CNT_LOAD;
                end
            end
            S_SETTLE: begin
                if (raw_changed) begin
                    snap_a_d = in_port_a;
                    snap_b_d = in_port_b;
                    count_d  = CNT_LOAD;
                end else if (count_q == '0) begin
                    state_d = S_ADD;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            S_ADD: begin
                data_a_d = snap_a_q;
                data_b_d = snap_b_q;
                result_d = {1'b0, snap_a_q} + {1'b0, snap_b_q};
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status and control registers; a hardware set beats a same-cycle W1C.
    always_comb begin
        done_d   = done_q;
        missed_d = missed_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        if (stat_wr && writedata[0]) done_d = 1'b0;
        if (stat_wr && writedata[2]) missed_d = 1'b0;
        if (state_q == S_DONE) done_d = 1'b1;
        if (start_req && busy) missed_d = 1'b1;
        if (ctrl_wr) begin
            auto_d   = writedata[1];
            irq_en_d = writedata[2];
        end
    end

    // Read mux, registered every cycle; reads have no side effects.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA_A:  readdata_d = 32'(data_a_q);
            ADDR_DATA_B:  readdata_d = 32'(data_b_q);
            ADDR_RESULT:  readdata_d = 32'(result_q);
            ADDR_STATUS:  readdata_d = {29'd0, missed_q, busy, done_q};
            ADDR_CONTROL: readdata_d = {29'd0, irq_en_q, auto_q, 1'b0};
            default:      readdata_d = '0;
        endcase
    end

    // State and register file flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            snap_a_q   <= '0;
            snap_b_q   <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            missed_q   <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            snap_a_q   <= snap_a_d;
            snap_b_q   <= snap_b_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            result_q   <= result_d;
            done_q     <= done_d;
            missed_q   <= missed_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign sum_out  = result_q;
    assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed and randomized checks of adder_operand_sequencer.
module tb_adder_operand_sequencer;

    localparam int DATA_W = 2;
    localparam int STABLE = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [2:0]        address = '0;
    logic              chipselect = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] in_port_a = '0;
    logic [DATA_W-1:0] in_port_b = '0;
    logic [DATA_W:0]   sum_out;
    logic              irq;

    int n_chk = 0;
    int n_fail = 0;

    adder_operand_sequencer #(
        .DATA_W       (DATA_W),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port_a (in_port_a),
        .in_port_b (in_port_b),
        .sum_out   (sum_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] d;
    logic [3:0]  seq [32];
    int          nb;
    int          add_edge;
    int          run;
    logic [2:0]  exp_sum;
    bit          seen;

    initial begin
        // Reset state: every register reads zero.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            chk($sformatf("reset_rd%0d", i), d, 32'h0);
        end
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_sum", 32'(sum_out), 32'h0);

        // Basic 3+2 with irq enabled; W1C on the done-setting edge loses.
        in_port_a = 2'd3;
        in_port_b = 2'd2;
        wr(3'd4, 32'h5);                 // E0
        repeat (4) tick();               // E0+4
        chk("t2_sum_e4", 32'(sum_out), 32'h0);
        tick();                          // E0+5
        chk("t2_sum_e5", 32'(sum_out), 32'h5);
        chk("t2_irq_e5", 32'(irq), 32'h0);
        wr(3'd3, 32'h1);                 // E0+6: set wins over clear
        chk("t2_irq_e6", 32'(irq), 32'h1);
        rd(3'd3, d);
        chk("t2_status", d, 32'h1);
        rd(3'd2, d);
        chk("t2_result", d, 32'h5);
        rd(3'd0, d);
        chk("t2_data_a", d, 32'h3);
        rd(3'd1, d);
        chk("t2_data_b", d, 32'h2);
        wr(3'd3, 32'h1);
        chk("t2_irq_clr", 32'(irq), 32'h0);

        // Input change inside SETTLE restarts the window.
        in_port_a = 2'd1;
        in_port_b = 2'd1;
        wr(3'd4, 32'h5);                 // E0
        tick();                          // E0+1
        in_port_a = 2'd2;
        repeat (5) tick();               // E0+6
        chk("t3_sum_e6", 32'(sum_out), 32'h5);
        tick();                          // E0+7
        chk("t3_sum_e7", 32'(sum_out), 32'h3);
        tick();                          // E0+8
        chk("t3_irq_e8", 32'(irq), 32'h1);
        rd(3'd0, d);
        chk("t3_data_a", d, 32'h2);
        wr(3'd3, 32'h1);

        // Start while busy is ignored and sets missed.
        in_port_a = 2'd2;
        in_port_b = 2'd1;
        wr(3'd4, 32'h1);                 // E0
        wr(3'd4, 32'h1);                 // E0+1
        rd(3'd3, d);                     // E0+2
        chk("t4_status_settle", d, 32'h6);
        repeat (4) tick();               // E0+6
        rd(3'd3, d);
        chk("t4_status_done", d, 32'h5);
        chk("t4_sum", 32'(sum_out), 32'h3);
        chk("t4_irq_off", 32'(irq), 32'h0);
        wr(3'd3, 32'h5);
        repeat (10) tick();
        rd(3'd3, d);
        chk("t4_single", d, 32'h0);

        // Auto mode: input change alone triggers, no re-trigger afterwards.
        do_reset();
        in_port_a = 2'd0;
        in_port_b = 2'd0;
        wr(3'd4, 32'h6);
        repeat (3) tick();
        rd(3'd3, d);
        chk("t5_idle", d, 32'h0);
        in_port_a = 2'd2;
        in_port_b = 2'd3;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (irq) seen = 1'b1;
        end
        chk("t5_irq_seen", 32'(seen), 32'h1);
        chk("t5_sum", 32'(sum_out), 32'h5);
        rd(3'd2, d);
        chk("t5_result", d, 32'h5);
        wr(3'd3, 32'h1);
        repeat (10) tick();
        rd(3'd3, d);
        chk("t5_no_retrig", d, 32'h0);
        chk("t5_irq_low", 32'(irq), 32'h0);

        // Reset inside SETTLE discards the sequence.
        do_reset();
        in_port_a = 2'd1;
        in_port_b = 2'd2;
        wr(3'd4, 32'h5);                 // E0
        tick();                          // E0+1
        reset = 1'b1;
        tick();                          // E0+2
        reset = 1'b0;
        repeat (10) tick();
        chk("t6_irq", 32'(irq), 32'h0);
        chk("t6_sum", 32'(sum_out), 32'h0);
        rd(3'd3, d);
        chk("t6_status", d, 32'h0);
        rd(3'd4, d);
        chk("t6_control", d, 32'h0);
        rd(3'd2, d);
        chk("t6_result", d, 32'h0);

        // Random bouncing inputs against a stable-run model: the add happens
        // on the first edge that completes STABLE consecutive repeats.
        for (int it = 0; it < 20; it++) begin
            nb = $urandom_range(0, 8);
            seq[0] = 4'($urandom);
            for (int j = 1; j < 32; j++)
                seq[j] = (j <= nb) ? 4'($urandom) : seq[nb];
            run = 0;
            add_edge = -1;
            for (int j = 1; j < 32 && add_edge < 0; j++) begin
                run = (seq[j] == seq[j-1]) ? run + 1 : 0;
                if (run == STABLE) add_edge = j;
            end
            exp_sum = 3'(seq[add_edge][3:2]) + 3'(seq[add_edge][1:0]);
            {in_port_a, in_port_b} = seq[0];
            wr(3'd4, 32'h5);             // E0
            for (int k = 1; k <= add_edge + 2; k++) begin
                {in_port_a, in_port_b} = seq[k];
                tick();
                if (k == add_edge + 1) begin
                    chk($sformatf("rnd%0d_sum", it), 32'(sum_out), 32'(exp_sum));
                    chk($sformatf("rnd%0d_irq_early", it), 32'(irq), 32'h0);
                end
                if (k == add_edge + 2)
                    chk($sformatf("rnd%0d_irq", it), 32'(irq), 32'h1);
            end
            rd(3'd0, d);
            chk($sformatf("rnd%0d_data_a", it), d, 32'(seq[add_edge][3:2]));
            wr(3'd3, 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
